// File: rtl/lda_pkg.sv
// Shared types and widths for the LDA line-drawing engine.
// Holds coordinate/colour widths, error width, engine states and point type.
package lda_pkg;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int C_W   = 3;
  localparam int ERR_W = 11;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SETUP,
    DRAW,
    DONE
  } state_t;

  // y is carried at X_W so that steep lines can swap x and y freely
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [X_W-1:0] y;
  } point_t;

endpackage

// File: rtl/lda_abs_diff.sv
// Combinational unsigned |a-b| with borrow-based ordering flag.
// Ports: a_i, b_i operands; diff_o = |a-b|; lt_o = (a < b).
module lda_abs_diff #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         lt_o
);

  logic [W:0] sub;

  assign sub    = {1'b0, a_i} - {1'b0, b_i};
  assign lt_o   = sub[W];
  assign diff_o = lt_o ? (b_i - a_i) : sub[W-1:0];

endmodule

// File: rtl/lda_line_engine.sv
// Bresenham line engine: latches a line on go, emits one pixel per DRAW cycle.
// Ports: clk, reset_n, go, x0/y0/x1/y1/color in; busy, done, vga_x/y/color/plot
// out. Macro LDA_ENGINE_BACKPRESSURE_EN adds input vga_ready to stall DRAW.
module lda_line_engine
  import lda_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           go,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  input  logic [C_W-1:0] color,
`ifdef LDA_ENGINE_BACKPRESSURE_EN
  input  logic           vga_ready,
`endif
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_color,
  output logic           vga_plot
);

  state_t state_q, state_d;

  point_t p0_q, p0_d;
  point_t p1_q, p1_d;
  point_t pa_q, pa_d;
  point_t pb_q, pb_d;

  logic [C_W-1:0] col_q, col_d;
  logic steep_q, steep_d;
  logic yneg_q, yneg_d;

  logic [X_W-1:0] dx_q, dx_d;
  logic [X_W-1:0] dy_q, dy_d;
  logic [X_W-1:0] cx_q, cx_d;
  logic [X_W-1:0] cy_q, cy_d;

  logic [ERR_W-1:0] err_q, err_d;
  logic [ERR_W-1:0] err_nx;
  logic             err_pos;

  logic [X_W-1:0] adx, ady, ads, dx_c;
  logic           x_rev, y_rev, ya_lt;
  logic           steep_c, swap_c;
  point_t         sa, sb;
  logic           adv;

`ifdef LDA_ENGINE_BACKPRESSURE_EN
  assign adv = vga_ready;
`else
  assign adv = 1'b1;
`endif

  // x_rev: x1 < x0, y_rev: y1 < y0 (decide the point swap)
  lda_abs_diff #(.W(X_W)) u_adx (
    .a_i   (p1_q.x),
    .b_i   (p0_q.x),
    .diff_o(adx),
    .lt_o  (x_rev)
  );

  lda_abs_diff #(.W(X_W)) u_ady (
    .a_i   (p1_q.y),
    .b_i   (p0_q.y),
    .diff_o(ady),
    .lt_o  (y_rev)
  );

  lda_abs_diff #(.W(X_W)) u_ads (
    .a_i   (pa_q.y),
    .b_i   (pb_q.y),
    .diff_o(ads),
    .lt_o  (ya_lt)
  );

  assign steep_c = ady > adx;
  assign sa      = steep_c ? point_t'({p0_q.y, p0_q.x}) : p0_q;
  assign sb      = steep_c ? point_t'({p1_q.y, p1_q.x}) : p1_q;
  // after the steep swap the major axis of the points is the old y
  assign swap_c  = steep_c ? y_rev : x_rev;

  assign dx_c    = pb_q.x - pa_q.x;
  assign err_nx  = err_q + {{(ERR_W-X_W){1'b0}}, dy_q};
  assign err_pos = !err_nx[ERR_W-1] && (|err_nx);

  assign vga_x     = steep_q ? cy_q : cx_q;
  assign vga_y     = steep_q ? cx_q[Y_W-1:0] : cy_q[Y_W-1:0];
  assign vga_color = col_q;

  always_comb begin
    state_d  = state_q;
    p0_d     = p0_q;
    p1_d     = p1_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    col_d    = col_q;
    steep_d  = steep_q;
    yneg_d   = yneg_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    err_d    = err_q;
    busy     = 1'b0;
    done     = 1'b0;
    vga_plot = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (go) begin
          p0_d    = '{x: x0, y: {1'b0, y0}};
          p1_d    = '{x: x1, y: {1'b0, y1}};
          col_d   = color;
          state_d = INIT;
        end
      end
      INIT: begin
        busy    = 1'b1;
        steep_d = steep_c;
        pa_d    = swap_c ? sb : sa;
        pb_d    = swap_c ? sa : sb;
        state_d = SETUP;
      end
      SETUP: begin
        busy    = 1'b1;
        dx_d    = dx_c;
        dy_d    = ads;
        yneg_d  = !ya_lt;
        err_d   = '0 - {{(ERR_W-X_W+1){1'b0}}, dx_c[X_W-1:1]};
        cx_d    = pa_q.x;
        cy_d    = pa_q.y;
        state_d = DRAW;
      end
      DRAW: begin
        busy     = 1'b1;
        vga_plot = 1'b1;
        if (adv) begin
          if (err_pos) begin
            cy_d  = yneg_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
            err_d = err_nx - {{(ERR_W-X_W){1'b0}}, dx_q};
          end else begin
            err_d = err_nx;
          end
          cx_d = cx_q + 1'b1;
          if (cx_q == pb_q.x) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      p0_q    <= '0;
      p1_q    <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      col_q   <= '0;
      steep_q <= 1'b0;
      yneg_q  <= 1'b0;
      dx_q    <= '0;
      dy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      col_q   <= col_d;
      steep_q <= steep_d;
      yneg_q  <= yneg_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lda_line_engine.sv
// Self-checking bench for lda_line_engine.
// Table of directed lines plus reset and stall sequences.
module tb_lda_line_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic [8:0] x0 = '0;
  logic [7:0] y0 = '0;
  logic [8:0] x1 = '0;
  logic [7:0] y1 = '0;
  logic [2:0] color = '0;
  logic       vga_ready = 1'b1;

  logic       busy, done, vga_plot;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;

  always #5 clk = ~clk;

  lda_line_engine dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .go       (go),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .color    (color),
`ifdef LDA_ENGINE_BACKPRESSURE_EN
    .vga_ready(vga_ready),
`endif
    .busy     (busy),
    .done     (done),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_color(vga_color),
    .vga_plot (vga_plot)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  logic [8:0] gx[$];
  logic [7:0] gy[$];
  logic [2:0] gc[$];
  int         gcyc[$];
  logic       gacc[$];
  int done_n, done_at, busy_n, first_busy;

  // go is driven in cycle 0; cycle k outputs are sampled at negedge k
  task automatic run(input logic [8:0] ax0, input logic [7:0] ay0,
                     input logic [8:0] ax1, input logic [7:0] ay1,
                     input logic [2:0] ac, input int go2, input int rstp,
                     input int rlo, input int rlen);
    gx.delete(); gy.delete(); gc.delete(); gcyc.delete(); gacc.delete();
    done_n = 0; done_at = -1; busy_n = 0; first_busy = -1;
    @(negedge clk);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1; color = ac;
    go = 1'b1; vga_ready = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      go = 1'b0;
      vga_ready = 1'b1;
      if (k == go2) begin
        go = 1'b1;
        x0 = 9'd100; y0 = 8'd50; x1 = 9'd7; y1 = 8'd9; color = 3'd1;
      end
      if (k >= rlo && k < rlo + rlen) vga_ready = 1'b0;
      if (busy) begin
        busy_n++;
        if (first_busy < 0) first_busy = k;
      end
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (vga_plot) begin
        gx.push_back(vga_x); gy.push_back(vga_y); gc.push_back(vga_color);
        gcyc.push_back(k); gacc.push_back(vga_ready);
      end
      if (rstp > 0 && reset_n && gx.size() == rstp) begin
        reset_n = 1'b0;
        go = 1'b0;
        #1;
        chk("rst_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x", vga_x, 0);
      end
      if (done_at >= 0 && k >= done_at + 6) break;
    end
    go = 1'b0;
    vga_ready = 1'b1;
  endtask

  typedef struct {
    string      nm;
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [2:0] c;
    int         n;
    logic [3:0][8:0] ex;
    logic [3:0][7:0] ey;
    int         go2;
  } vec_t;

  vec_t tv[6];

  task automatic check_line(input vec_t v);
    int m;
    chk({v.nm, "_count"}, gx.size(), v.n);
    m = (gx.size() < v.n) ? gx.size() : v.n;
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_x%0d", v.nm, i), gx[i], v.ex[i]);
      chk($sformatf("%s_y%0d", v.nm, i), gy[i], v.ey[i]);
      chk($sformatf("%s_c%0d", v.nm, i), gc[i], v.c);
    end
    if (gx.size() > 0) begin
      chk({v.nm, "_first_cyc"}, gcyc[0], 3);
      chk({v.nm, "_done_cyc"}, done_at, gcyc[gcyc.size()-1] + 1);
    end
    chk({v.nm, "_done_n"}, done_n, 1);
    chk({v.nm, "_busy_n"}, busy_n, v.n + 2);
    chk({v.nm, "_busy_first"}, first_busy, 1);
    chk({v.nm, "_hold_col"}, vga_color, v.c);
  endtask

  initial begin
    tv[0] = '{"horiz", 9'd0, 8'd0, 9'd3, 8'd0, 3'd5, 4,
              {9'd3, 9'd2, 9'd1, 9'd0}, {8'd0, 8'd0, 8'd0, 8'd0}, 0};
    tv[1] = '{"steep", 9'd0, 8'd0, 9'd1, 8'd3, 3'd2, 4,
              {9'd1, 9'd1, 9'd0, 9'd0}, {8'd3, 8'd2, 8'd1, 8'd0}, 0};
    tv[2] = '{"rev", 9'd335, 8'd0, 9'd333, 8'd2, 3'd7, 3,
              {9'd0, 9'd335, 9'd334, 9'd333}, {8'd0, 8'd0, 8'd1, 8'd2}, 0};
    tv[3] = '{"degen", 9'd5, 8'd5, 9'd5, 8'd5, 3'd3, 1,
              {9'd0, 9'd0, 9'd0, 9'd5}, {8'd0, 8'd0, 8'd0, 8'd5}, 2};
    tv[4] = '{"vert_up", 9'd4, 8'd7, 9'd4, 8'd4, 3'd6, 4,
              {9'd4, 9'd4, 9'd4, 9'd4}, {8'd7, 8'd6, 8'd5, 8'd4}, 0};
    tv[5] = '{"post_rst", 9'd2, 8'd2, 9'd4, 8'd2, 3'd4, 3,
              {9'd0, 9'd4, 9'd3, 9'd2}, {8'd0, 8'd2, 8'd2, 8'd2}, 0};

    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_plot", vga_plot, 0);
    chk("reset_x", vga_x, 0);
    chk("reset_y", vga_y, 0);
    chk("reset_color", vga_color, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run(tv[i].x0, tv[i].y0, tv[i].x1, tv[i].y1, tv[i].c,
          tv[i].go2, 0, 0, 0);
      check_line(tv[i]);
    end

    // abandon a long line after its 4th plot
    run(9'd0, 8'd0, 9'd10, 8'd0, 3'd4, 0, 4, 0, 0);
    chk("midrst_plots", gx.size(), 4);
    chk("midrst_done_n", done_n, 0);
    chk("midrst_busy_n", busy_n, 6);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle_busy", busy, 0);
    run(tv[5].x0, tv[5].y0, tv[5].x1, tv[5].y1, tv[5].c, 0, 0, 0, 0);
    check_line(tv[5]);

`ifdef LDA_ENGINE_BACKPRESSURE_EN
    // (1,0) is presented in cycle 4; stall it for cycles 4 and 5
    begin
      int acc;
      logic [8:0] bx[6];
      bx = '{9'd0, 9'd1, 9'd1, 9'd1, 9'd2, 9'd3};
      run(9'd0, 8'd0, 9'd3, 8'd0, 3'd5, 0, 0, 4, 2);
      chk("bp_plot_cycles", gx.size(), 6);
      for (int i = 0; i < 6 && i < gx.size(); i++) begin
        chk($sformatf("bp_x%0d", i), gx[i], bx[i]);
        chk($sformatf("bp_y%0d", i), gy[i], 0);
      end
      acc = 0;
      for (int i = 0; i < gacc.size(); i++) if (gacc[i]) acc++;
      chk("bp_accepts", acc, 4);
      chk("bp_done_n", done_n, 1);
      chk("bp_done_cyc", done_at, 9);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
